key_event_encoder: RTL and testbench
====================================

KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 Parameter DEBOUNCE_SAMPLES, default 3, range 1..15: number of consecutive differing samples required to accept a key change.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two 2..16: event queue depth.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 sample_en  in  1  one-cycle sample strobe, typically the keypad scan rate.
REQ-006 buttons  in  16  raw key levels from the keypad scanner; bit i = key i; 1 = pressed.
REQ-007 ev_valid  out  1  event available at the queue head.
REQ-008 ev_ready  in  1  consumer accepts the head event.
REQ-009 ev_data  out  5  {release, index[3:0]}; release = 1 for a release event, 0 for a press event.
REQ-010 fifo_level  out  clog2(FIFO_DEPTH)+1  number of queued events.
REQ-011 key_state  out  16  debounced key levels.

Function
REQ-012 Per key, the block SHALL hold a debounced bit (key_state[i]), a debounce counter, and a pending bit.
REQ-013 On a cycle with sample_en=1 and pending[i]=0:
- if buttons[i]==key_state[i]: counter[i] clears;
- else: counter[i] increments.
REQ-014 A change SHALL be accepted when the increment makes counter[i] equal DEBOUNCE_SAMPLES. On acceptance, in the same edge:
- key_state[i] toggles;
- counter[i] clears;
- pending[i] sets.
REQ-015 While pending[i]=1, counter[i] and key_state[i] SHALL be frozen; samples of key i are ignored.
REQ-016 Cycles with sample_en=0 SHALL leave every counter unchanged.
REQ-017 Each cycle, if any pending bit is set and the FIFO is not full at the start of the cycle:
- the lowest-indexed pending key is pushed as {~key_state[k], k};
- pending[k] clears.
At most one push per cycle.
REQ-018 Push SHALL NOT be allowed when the FIFO is full, even if a pop occurs in the same cycle; the pending bit holds and no event is lost.
REQ-019 ev_valid SHALL be 1 exactly when fifo_level>0. ev_data SHALL present the head event and remain stable while ev_valid=1 and ev_ready=0.
REQ-020 A pop SHALL occur on a cycle with ev_valid&&ev_ready. Push and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-021 ev_ready while empty SHALL have no effect.
REQ-022 Latency: acceptance edge N → push at edge N+1 → ev_valid=1 after edge N+1 (empty FIFO, no other pending keys).
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Simultaneous acceptances on several keys SHALL be queued in ascending index order, one per cycle.

Reset
REQ-025 rst_n=0 SHALL immediately clear the following, regardless of clk:
- key_state=0;
- all counters=0;
- pending=0;
- FIFO pointers=0;
- fifo_level=0;
- ev_valid=0.
ev_data is then don't-care.
REQ-026 Reset asserted mid-operation SHALL discard queued and pending events. The first edge after deassertion SHALL behave as normal operation.

Configuration
REQ-027 Macro KEY_EVENT_RELEASE_EN:
- defined: press and release acceptances both set pending and generate events;
- undefined: a release acceptance updates key_state only and sets no pending bit, and ev_data[4] is always 0.

Verification
REQ-028 DEBOUNCE_SAMPLES=3:
- buttons[5]=1 for 3 sample_en strobes → key_state[5]=1 at the 3rd strobe edge;
- ev_valid=1 one edge later with ev_data=5'h05.
REQ-029 Bounce rejection: buttons[2] toggles 1,1,0,1,1 across strobes → no acceptance until the 3rd consecutive 1; exactly one event 5'h02.
REQ-030 Keys 9, 3 and 12 accepted on the same edge, ev_ready=1 → ev_data sequence 5'h03, 5'h09, 5'h0C on consecutive cycles.
REQ-031 FIFO_DEPTH=4, ev_ready=0, 6 keys accepted:
- fifo_level saturates at 4, with 2 keys still pending;
- after popping all events, 6 events arrive in index order with none lost.
REQ-032 Press then release of key 0:
- KEY_EVENT_RELEASE_EN defined → 5'h00 then 5'h10;
- undefined → 5'h00 only, and key_state[0] returns to 0.
REQ-033 rst_n pulsed low with 3 events queued → ev_valid=0 and fifo_level=0 immediately; key_state=0.

Source files
------------

// File: rtl/key_event_encoder_if.sv
// Event handshake bundle for key_event_encoder.
// The master side (the encoder) offers queued key events; the slave side
// (the consumer) accepts the head event by raising ev_ready.
interface key_event_encoder_if;

   logic       ev_valid;
   logic       ev_ready;
   logic [4:0] ev_data;

   modport master (
      output ev_valid,
      output ev_data,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_data,
      output ev_ready
   );

endinterface

// File: rtl/key_event_encoder.sv
// key_event_encoder: debounces 16 raw key levels and queues press/release
// events into a small FIFO, lowest key index first.
// Optional feature macro: KEY_EVENT_RELEASE_EN -- when defined, release
// acceptances also generate events; otherwise only presses are queued.
module key_event_encoder #(
   parameter int DEBOUNCE_SAMPLES = 3,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sample_en,
   input  logic [15:0]                  buttons,
   key_event_encoder_if.master          ev,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic [15:0]                  key_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
   localparam logic [4:0]  ACCEPT_COUNT = 5'(DEBOUNCE_SAMPLES);

`ifdef KEY_EVENT_RELEASE_EN
   localparam bit RELEASE_EN = 1'b1;
`else
   localparam bit RELEASE_EN = 1'b0;
`endif

   logic [3:0]    count [16];
   logic [15:0]   pending;
   logic [15:0]   accept;
   logic [15:0]   accept_event;
   logic [15:0]   push_clear;
   logic [3:0]    push_idx;
   logic [4:0]    push_data;
   logic          full;
   logic          push;
   logic          pop;
   logic [4:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // A key change is accepted when this strobe's increment would reach the debounce threshold
   always_comb begin
      accept = '0;
      for (int i = 0; i < 16; i++) begin
         accept[i] = sample_en && !pending[i] && (buttons[i] != key_state[i]) &&
                     ((5'(count[i]) + 5'd1) == ACCEPT_COUNT);
      end
   end

   // Only presses raise a pending event unless release reporting is enabled
   always_comb begin
      accept_event = RELEASE_EN ? accept : (accept & ~key_state);
   end

   // Lowest-indexed pending key wins the single push slot each cycle
   always_comb begin
      push_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (pending[i]) begin
            push_idx = 4'(i);
         end
      end
   end

   // Push is gated on the level at the start of the cycle, so a same-cycle pop never frees a slot
   always_comb begin
      full       = (fifo_level == FULL_LEVEL);
      push       = (|pending) && !full;
      pop        = ev.ev_valid && ev.ev_ready;
      push_clear = push ? (16'd1 << push_idx) : 16'd0;
      push_data  = {RELEASE_EN ? ~key_state[push_idx] : 1'b0, push_idx};
   end

   // Per-key debounce counters and debounced levels; frozen while the key has an unqueued event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_state <= '0;
         for (int i = 0; i < 16; i++) begin
            count[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (sample_en && !pending[i]) begin
               if (buttons[i] == key_state[i]) begin
                  count[i] <= 4'd0;
               end else if (accept[i]) begin
                  key_state[i] <= ~key_state[i];
                  count[i]     <= 4'd0;
               end else begin
                  count[i] <= count[i] + 4'd1;
               end
            end
         end
      end
   end

   // Pending bits set on accepted events and clear when that key is pushed into the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~push_clear) | accept_event;
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally since the depth is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Event storage; contents need no reset because the level gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign ev.ev_valid = (fifo_level != '0);
   assign ev.ev_data  = mem[rd_ptr];

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed testbench for key_event_encoder with default parameters
// (DEBOUNCE_SAMPLES=3, FIFO_DEPTH=4).
module tb_key_event_encoder;

   logic        clk;
   logic        rst_n;
   logic        sample_en;
   logic [15:0] buttons;
   logic [2:0]  fifo_level;
   logic [15:0] key_state;
   int          total;
   int          bad;

   key_event_encoder_if ev_if ();

   key_event_encoder #(
      .DEBOUNCE_SAMPLES(3),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sample_en(sample_en),
      .buttons(buttons),
      .ev(ev_if),
      .fifo_level(fifo_level),
      .key_state(key_state)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic reset_dut();
      buttons         = 16'h0000;
      sample_en       = 1'b0;
      ev_if.ev_ready  = 1'b0;
      rst_n           = 1'b0;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [15:0] b);
      buttons   = b;
      sample_en = 1'b1;
      @(posedge clk);
      #1;
      sample_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop_one();
      ev_if.ev_ready = 1'b1;
      @(posedge clk);
      #1;
      ev_if.ev_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      buttons        = 16'hFFFF;
      sample_en      = 1'b1;
      ev_if.ev_ready = 1'b1;
      idle(5);
      total++;
      if (ev_if.ev_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_valid: got %b expected 0", ev_if.ev_valid);
      end
      total++;
      if (fifo_level !== 3'd0) begin
         bad++;
         $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
      end
      total++;
      if (key_state !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL reset_keys: got %h expected 0000", key_state);
      end
      reset_dut();
   endtask

   task automatic test_press();
      reset_dut();
      strobe(16'h0020);
      strobe(16'h0020);
      total++;
      if (key_state !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL press_early: got %h expected 0000", key_state);
      end
      strobe(16'h0020);
      total++;
      if (key_state !== 16'h0020) begin
         bad++;
         $display("[TB] FAIL press_accept: got %h expected 0020", key_state);
      end
      total++;
      if (ev_if.ev_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL press_latency: got valid %b expected 0", ev_if.ev_valid);
      end
      idle(1);
      total++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== 5'h05 || fifo_level !== 3'd1) begin
         bad++;
         $display("[TB] FAIL press_event: got valid %b data %h level %0d expected 1 05 1",
                  ev_if.ev_valid, ev_if.ev_data, fifo_level);
      end
      pop_one();
      total++;
      if (ev_if.ev_valid !== 1'b0 || fifo_level !== 3'd0) begin
         bad++;
         $display("[TB] FAIL press_pop: got valid %b level %0d expected 0 0",
                  ev_if.ev_valid, fifo_level);
      end
   endtask

   task automatic test_bounce();
      reset_dut();
      strobe(16'h0004);
      strobe(16'h0004);
      strobe(16'h0000);
      strobe(16'h0004);
      strobe(16'h0004);
      idle(2);
      total++;
      if (key_state !== 16'h0000 || ev_if.ev_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bounce_reject: got keys %h valid %b expected 0000 0",
                  key_state, ev_if.ev_valid);
      end
      buttons = 16'h0004;
      strobe(16'h0004);
      total++;
      if (key_state !== 16'h0004) begin
         bad++;
         $display("[TB] FAIL bounce_accept: got %h expected 0004", key_state);
      end
      idle(3);
      total++;
      if (ev_if.ev_data !== 5'h02 || fifo_level !== 3'd1) begin
         bad++;
         $display("[TB] FAIL bounce_event: got data %h level %0d expected 02 1",
                  ev_if.ev_data, fifo_level);
      end
      pop_one();
      idle(3);
      total++;
      if (ev_if.ev_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bounce_single: got valid %b expected 0", ev_if.ev_valid);
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] exp_seq [3];
      exp_seq[0] = 5'h03;
      exp_seq[1] = 5'h09;
      exp_seq[2] = 5'h0C;
      reset_dut();
      ev_if.ev_ready = 1'b1;
      strobe(16'h1208);
      strobe(16'h1208);
      strobe(16'h1208);
      total++;
      if (key_state !== 16'h1208) begin
         bad++;
         $display("[TB] FAIL simul_keys: got %h expected 1208", key_state);
      end
      for (int k = 0; k < 3; k++) begin
         idle(1);
         total++;
         if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== exp_seq[k]) begin
            bad++;
            $display("[TB] FAIL simul_order%0d: got valid %b data %h expected 1 %h",
                     k, ev_if.ev_valid, ev_if.ev_data, exp_seq[k]);
         end
      end
      idle(1);
      total++;
      if (ev_if.ev_valid !== 1'b0 || fifo_level !== 3'd0) begin
         bad++;
         $display("[TB] FAIL simul_drain: got valid %b level %0d expected 0 0",
                  ev_if.ev_valid, fifo_level);
      end
      ev_if.ev_ready = 1'b0;
   endtask

   task automatic test_fifo_full();
      reset_dut();
      strobe(16'h003F);
      strobe(16'h003F);
      strobe(16'h003F);
      idle(4);
      total++;
      if (fifo_level !== 3'd4) begin
         bad++;
         $display("[TB] FAIL full_level: got %0d expected 4", fifo_level);
      end
      idle(3);
      total++;
      if (fifo_level !== 3'd4 || ev_if.ev_data !== 5'h00) begin
         bad++;
         $display("[TB] FAIL full_hold: got level %0d data %h expected 4 00",
                  fifo_level, ev_if.ev_data);
      end
      ev_if.ev_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         total++;
         if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== 5'(k)) begin
            bad++;
            $display("[TB] FAIL full_drain%0d: got valid %b data %h expected 1 %h",
                     k, ev_if.ev_valid, ev_if.ev_data, 5'(k));
         end
         @(posedge clk);
         #1;
      end
      ev_if.ev_ready = 1'b0;
      total++;
      if (fifo_level !== 3'd0 || ev_if.ev_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL full_empty: got level %0d valid %b expected 0 0",
                  fifo_level, ev_if.ev_valid);
      end
   endtask

   task automatic test_release();
      reset_dut();
      strobe(16'h0001);
      strobe(16'h0001);
      strobe(16'h0001);
      idle(1);
      total++;
      if (ev_if.ev_data !== 5'h00 || fifo_level !== 3'd1) begin
         bad++;
         $display("[TB] FAIL release_press: got data %h level %0d expected 00 1",
                  ev_if.ev_data, fifo_level);
      end
      pop_one();
      strobe(16'h0000);
      strobe(16'h0000);
      strobe(16'h0000);
      total++;
      if (key_state !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL release_keys: got %h expected 0000", key_state);
      end
      idle(2);
`ifdef KEY_EVENT_RELEASE_EN
      total++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== 5'h10) begin
         bad++;
         $display("[TB] FAIL release_event: got valid %b data %h expected 1 10",
                  ev_if.ev_valid, ev_if.ev_data);
      end
`else
      total++;
      if (ev_if.ev_valid !== 1'b0 || fifo_level !== 3'd0) begin
         bad++;
         $display("[TB] FAIL release_silent: got valid %b level %0d expected 0 0",
                  ev_if.ev_valid, fifo_level);
      end
`endif
   endtask

   task automatic test_reset_mid();
      reset_dut();
      strobe(16'h000E);
      strobe(16'h000E);
      strobe(16'h000E);
      idle(4);
      total++;
      if (fifo_level !== 3'd3) begin
         bad++;
         $display("[TB] FAIL mid_queued: got %0d expected 3", fifo_level);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (ev_if.ev_valid !== 1'b0 || fifo_level !== 3'd0 || key_state !== 16'h0000) begin
         bad++;
         $display("[TB] FAIL mid_reset: got valid %b level %0d keys %h expected 0 0 0000",
                  ev_if.ev_valid, fifo_level, key_state);
      end
      buttons = 16'h0000;
      #2;
      rst_n = 1'b1;
      idle(3);
      total++;
      if (ev_if.ev_valid !== 1'b0 || fifo_level !== 3'd0) begin
         bad++;
         $display("[TB] FAIL mid_after: got valid %b level %0d expected 0 0",
                  ev_if.ev_valid, fifo_level);
      end
   endtask

   // Runs every scenario in order and reports the totals
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_press();
      test_bounce();
      test_simultaneous();
      test_fifo_full();
      test_release();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
